// File: rtl/seq_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : seq_control_unit
// Function : Fetch/decode/execute sequencer for the 8-bit accumulator machine.
// Revision : 1.0 - initial release
// ============================================================================
module seq_control_unit #(
  parameter int ADDR_W  = 6,
  parameter int INSTR_W = 3 + ADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               restart,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               zero_flag,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_we,
  output logic               acc_load,
  output logic               acc_src,
  output logic [1:0]         alu_op,
  output logic               leds_load,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted,
  output logic               busy,
  output logic [2:0]         state,
  output logic [7:0]         retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOADIR = 3'd2,
    S_DECODE = 3'd3,
    S_EXEC   = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [2:0] c_OP_NOP = 3'b000;
  localparam logic [2:0] c_OP_LDA = 3'b001;
  localparam logic [2:0] c_OP_ADD = 3'b010;
  localparam logic [2:0] c_OP_SUB = 3'b011;
  localparam logic [2:0] c_OP_STA = 3'b100;
  localparam logic [2:0] c_OP_JMP = 3'b101;
  localparam logic [2:0] c_OP_JZ  = 3'b110;
  localparam logic [2:0] c_OP_SYS = 3'b111;

  localparam logic [1:0] c_SYS_IN   = 2'b00;
  localparam logic [1:0] c_SYS_OUT  = 2'b01;
  localparam logic [1:0] c_SYS_HALT = 2'b10;

  state_t              r_state, w_next_state;
  logic [ADDR_W-1:0]   r_pc, w_next_pc;
  logic [INSTR_W-1:0]  r_ir, w_next_ir;
  logic [7:0]          r_retired;
  logic                w_retire;
  logic [2:0]          w_opcode;
  logic [ADDR_W-1:0]   w_operand;
  logic [1:0]          w_subop;

  assign w_opcode  = r_ir[INSTR_W-1 -: 3];
  assign w_operand = r_ir[ADDR_W-1:0];
  assign w_subop   = r_ir[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_ir      <= '0;
      r_retired <= '0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
      r_ir    <= w_next_ir;
      if (w_retire && !restart)
        r_retired <= r_retired + 8'd1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_next_ir    = r_ir;
    w_retire     = 1'b0;
    mem_addr     = '0;
    mem_we       = 1'b0;
    acc_load     = 1'b0;
    acc_src      = 1'b0;
    alu_op       = 2'b00;
    leds_load    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (run)
          w_next_state = S_FETCH;
      end
      S_FETCH: begin
        mem_addr     = r_pc;
        w_next_state = S_LOADIR;
      end
      S_LOADIR: begin
        w_next_ir    = instr_in;
        w_next_pc    = r_pc + ADDR_W'(1);
        w_next_state = S_DECODE;
      end
      S_DECODE: begin
        w_retire = 1'b1;
        case (w_opcode)
          c_OP_LDA, c_OP_ADD, c_OP_SUB: begin
            mem_addr     = w_operand;
            w_retire     = 1'b0;
            w_next_state = S_EXEC;
          end
          c_OP_STA: begin
            mem_addr = w_operand;
            mem_we   = 1'b1;
          end
          c_OP_JMP: w_next_pc = w_operand;
          c_OP_JZ:  if (zero_flag) w_next_pc = w_operand;
          c_OP_SYS: begin
            case (w_subop)
              c_SYS_IN: begin
                acc_load = 1'b1;
                acc_src  = 1'b1;
              end
              c_SYS_OUT:  leds_load = 1'b1;
              c_SYS_HALT: w_next_state = S_HALT;
              default: ;
            endcase
          end
          c_OP_NOP: ;
          default: ;
        endcase
      end
      S_EXEC: begin
        mem_addr = w_operand;
        acc_load = 1'b1;
        w_retire = 1'b1;
        case (w_opcode)
          c_OP_ADD: alu_op = 2'b01;
          c_OP_SUB: alu_op = 2'b10;
          default:  alu_op = 2'b00;
        endcase
      end
      S_HALT: ;
      default: w_next_state = S_IDLE;
    endcase

    // A retiring cycle picks the boundary target unless it is entering HALT.
    if (w_retire && w_next_state != S_HALT)
      w_next_state = run ? S_FETCH : S_IDLE;

    if (restart) begin
      w_next_state = S_IDLE;
      w_next_pc    = '0;
      w_next_ir    = '0;
    end
  end

  assign pc      = r_pc;
  assign state   = r_state;
  assign retired = r_retired;
  assign halted  = (r_state == S_HALT);
  assign busy    = (r_state != S_IDLE) && (r_state != S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_seq_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_control_unit
// Function : Scoreboard bench for seq_control_unit with a synchronous-read ROM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_control_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       restart = 1'b0;
  logic       zero_flag = 1'b0;
  logic       use_rand = 1'b0;
  logic [8:0] instr_in, instr_q, rnd;
  logic [5:0] mem_addr, pc;
  logic       mem_we, acc_load, acc_src, leds_load, halted, busy;
  logic [1:0] alu_op;
  logic [2:0] state;
  logic [7:0] retired;
  logic [8:0] mem [64];

  int checks = 0;
  int errors = 0;

  // {acc_load, acc_src, alu_op, mem_we, leds_load, mem_addr}
  logic [11:0] stb_q[$];
  // {mem_addr, retired} seen in each FETCH cycle
  logic [13:0] fet_q[$];

  seq_control_unit dut (
    .clk(clk), .rst_n(rst_n), .run(run), .restart(restart),
    .instr_in(instr_in), .zero_flag(zero_flag),
    .mem_addr(mem_addr), .mem_we(mem_we), .acc_load(acc_load),
    .acc_src(acc_src), .alu_op(alu_op), .leds_load(leds_load),
    .pc(pc), .halted(halted), .busy(busy), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    instr_q <= mem[mem_addr];
    rnd     <= 9'($urandom);
  end
  assign instr_in = use_rand ? rnd : instr_q;

  function automatic logic [11:0] stb(input logic al, input logic as,
                                      input logic [1:0] op, input logic we,
                                      input logic ll, input logic [5:0] a);
    return {al, as, op, we, ll, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT fetches or fires a strobe.
  always @(negedge clk) begin
    if (rst_n) begin
      if (state == 3'd1) begin
        checks++;
        if (fet_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_fetch actual=%0h required=none", {mem_addr, retired});
        end else begin
          logic [13:0] e;
          e = fet_q.pop_front();
          if ({mem_addr, retired} !== e) begin
            errors++;
            $display("FAIL fetch actual=%0h required=%0h", {mem_addr, retired}, e);
          end
        end
      end
      if (acc_load || mem_we || leds_load) begin
        checks++;
        if (stb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe actual=%0h required=none",
                   {acc_load, acc_src, alu_op, mem_we, leds_load, mem_addr});
        end else begin
          logic [11:0] e;
          e = stb_q.pop_front();
          if ({acc_load, acc_src, alu_op, mem_we, leds_load, mem_addr} !== e) begin
            errors++;
            $display("FAIL strobe actual=%0h required=%0h",
                     {acc_load, acc_src, alu_op, mem_we, leds_load, mem_addr}, e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic begin_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    restart = 1'b0;
    run     = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 64; i++) mem[i] = 9'h1C2;
  endtask

  task automatic go();
    rst_n = 1'b1;
  endtask

  task automatic wait_halt(input string name);
    for (int i = 0; i < 60 && !halted; i++) tick();
    chk(name, halted, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    // Reset with random read data
    for (int i = 0; i < 64; i++) mem[i] = 9'h1C2;
    use_rand = 1'b1;
    begin_reset();
    tick();
    chk("rst_state", state, 0);
    chk("rst_pc", pc, 0);
    chk("rst_retired", retired, 0);
    chk("rst_strobes", {mem_we, acc_load, acc_src, leds_load, alu_op}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_flags", {halted, busy}, 0);
    use_rand = 1'b0;

    // LDA 5 then HALT
    mem[0] = 9'h045;
    fet_q.push_back({6'd0, 8'd0});
    stb_q.push_back(stb(1, 0, 2'b00, 0, 0, 6'd5));
    fet_q.push_back({6'd1, 8'd1});
    go();
    begin
      logic [2:0] exp_st [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1, 3'd2, 3'd3, 3'd5};
      for (int i = 0; i < 8; i++) begin
        tick();
        chk("lda_state", state, exp_st[i]);
        if (i == 2) chk("lda_decode_addr", mem_addr, 5);
      end
    end
    chk("lda_retired", retired, 2);
    chk("lda_pc", pc, 2);

    // JZ 20 taken
    begin_reset();
    mem[0] = 9'h194;
    zero_flag = 1'b1;
    fet_q.push_back({6'd0, 8'd0});
    fet_q.push_back({6'd20, 8'd1});
    go();
    wait_halt("jz1_halt");
    chk("jz1_pc", pc, 21);

    // JZ 20 not taken
    begin_reset();
    mem[0] = 9'h194;
    zero_flag = 1'b0;
    fet_q.push_back({6'd0, 8'd0});
    fet_q.push_back({6'd1, 8'd1});
    go();
    wait_halt("jz0_halt");
    chk("jz0_pc", pc, 2);

    // IN, OUT, HALT, then restart
    begin_reset();
    mem[0] = 9'h1C0;
    mem[1] = 9'h1C1;
    mem[2] = 9'h1C2;
    fet_q.push_back({6'd0, 8'd0});
    fet_q.push_back({6'd1, 8'd1});
    fet_q.push_back({6'd2, 8'd2});
    stb_q.push_back(stb(1, 1, 2'b00, 0, 0, 6'd0));
    stb_q.push_back(stb(0, 0, 2'b00, 0, 1, 6'd0));
    go();
    for (int cyc = 1; cyc <= 10; cyc++) begin
      tick();
      if (cyc == 3) chk("in_strobe", {acc_load, acc_src}, 2'b11);
      if (cyc == 6) chk("out_strobe", leds_load, 1);
      if (cyc == 9) chk("halt_not_yet", halted, 0);
    end
    chk("halt_entry", {halted, busy, state}, {2'b10, 3'd5});
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("halt_hold", {halted, busy, state}, {2'b10, 3'd5});
    end
    run = 1'b0;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("restart_state", state, 0);
    chk("restart_pc", pc, 0);
    chk("restart_halted", halted, 0);
    chk("restart_retired", retired, 3);
    tick();
    chk("restart_idle", {state, busy}, 0);

    // JMP 63, NOP at 63 wraps pc to 0
    begin_reset();
    mem[0]  = 9'h17F;
    mem[63] = 9'h000;
    fet_q.push_back({6'd0, 8'd0});
    fet_q.push_back({6'd63, 8'd1});
    fet_q.push_back({6'd0, 8'd2});
    go();
    for (int i = 0; i < 7; i++) tick();
    chk("wrap_fetch", {state, mem_addr}, {3'd1, 6'd0});
    run = 1'b0;
    tick();
    tick();
    tick();
    chk("wrap_stop", {state, pc, retired}, {3'd0, 6'd63, 8'd3});

    // ADD 7 with run dropped in EXEC, then resume
    begin_reset();
    mem[0] = 9'h087;
    fet_q.push_back({6'd0, 8'd0});
    stb_q.push_back(stb(1, 0, 2'b01, 0, 0, 6'd7));
    go();
    for (int i = 0; i < 4; i++) tick();
    chk("add_exec", {state, acc_load, alu_op}, {3'd4, 1'b1, 2'b01});
    run = 1'b0;
    tick();
    chk("add_stop", {state, pc, retired}, {3'd0, 6'd1, 8'd1});
    tick();
    chk("add_idle_hold", state, 0);
    fet_q.push_back({6'd1, 8'd1});
    run = 1'b1;
    wait_halt("add_resume_halt");
    chk("add_resume_retired", retired, 2);

    // STA 9 cut by reset during DECODE
    begin_reset();
    mem[0] = 9'h109;
    fet_q.push_back({6'd0, 8'd0});
    go();
    tick();
    tick();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("sta_reset", {state, mem_we, pc, retired}, 0);
    tick();
    chk("sta_reset_hold", {state, mem_we}, 0);

    chk("fetch_queue_empty", fet_q.size(), 0);
    chk("strobe_queue_empty", stb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
